// File: rtl/timer_peripheral.sv
// Memory-mapped interval timer, LED register, switch input and system tick for the core's data bus.
// Latency: reads are combinational (0 cycles); stores commit on the next rising edge of clk.
// Backpressure: none; every access completes in the cycle it is presented, so no stall is ever raised.
//
// Ports:
//   clk, reset            single clock, asynchronous active-low reset
//   iAddr/iMemRead/iMemWrite/iWriteData   MEM-stage bus from the core
//   oReadData, oHit       combinational read data and window hit for the outer bus mux
//   oInterrupt            timer IRQ (TCON[1] & TCON[2])
//   oLed                  LED register output
//   iSwitch               asynchronous switch pins, double-flop synchronised
module timer_peripheral #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] iAddr,
    input  logic        iMemRead,
    input  logic        iMemWrite,
    input  logic [31:0] iWriteData,
    output logic [31:0] oReadData,
    output logic        oHit,
    output logic        oInterrupt,
    output logic [7:0]  oLed,
    input  logic [7:0]  iSwitch
);

    // Register word indices within the window (offset[4:2]).
    localparam logic [2:0] REG_TH      = 3'd0;
    localparam logic [2:0] REG_TL      = 3'd1;
    localparam logic [2:0] REG_TCON    = 3'd2;
    localparam logic [2:0] REG_LED     = 3'd3;
    localparam logic [2:0] REG_SWITCH  = 3'd4;
    localparam logic [2:0] REG_SYSTICK = 3'd5;

    localparam logic [31:0] WINDOW_BYTES = 32'h0000_0018;
    localparam logic [31:0] TL_MAX       = 32'hFFFF_FFFF;

    logic [31:0] th;
    logic [31:0] tl;
    logic [2:0]  tcon;
    logic [2:0]  tconNext;
    logic [7:0]  led;
    logic [7:0]  switchMeta;
    logic [7:0]  switchSync;
    logic [31:0] sysTick;

    logic [31:0] offset;
    logic        inWindow;
    logic [2:0]  regSel;
    logic        wrTh;
    logic        wrTl;
    logic        wrTcon;
    logic        wrLed;
    logic        wrSysTick;
    logic        overflow;

    // Subtracting the base first keeps the window test a single unsigned
    // compare; addresses below the base wrap to large offsets and miss.
    assign offset   = iAddr - BASE_ADDR;
    assign inWindow = (offset < WINDOW_BYTES);
    assign regSel   = offset[4:2];
    assign oHit     = (iMemRead | iMemWrite) & inWindow;

    assign wrTh      = iMemWrite & inWindow & (regSel == REG_TH);
    assign wrTl      = iMemWrite & inWindow & (regSel == REG_TL);
    assign wrTcon    = iMemWrite & inWindow & (regSel == REG_TCON);
    assign wrLed     = iMemWrite & inWindow & (regSel == REG_LED);
    assign wrSysTick = iMemWrite & inWindow & (regSel == REG_SYSTICK);

    assign overflow = tcon[0] & (tl == TL_MAX);

    // Reload value. A store landing on an overflow edge does not affect
    // that reload, because TL samples the old TH on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th <= '0;
        end else if (wrTh) begin
            th <= iWriteData;
        end
    end

    // Counter: a software store always wins over counting or reload.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tl <= '0;
        end else if (wrTl) begin
            tl <= iWriteData;
        end else if (tcon[0]) begin
            tl <= overflow ? th : (tl + 32'd1);
        end
    end

    // TCON: software writes bits directly, but a hardware status set on an
    // overflow edge overrides a simultaneous software clear so the IRQ is
    // never lost. An overflow swallowed by a TL store raises nothing.
    always_comb begin
        tconNext = tcon;
        if (wrTcon) begin
            tconNext = iWriteData[2:0];
        end
        if (overflow && tcon[1] && !wrTl) begin
            tconNext[2] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcon <= '0;
        end else begin
            tcon <= tconNext;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            led <= '0;
        end else if (wrLed) begin
            led <= iWriteData[7:0];
        end
    end

    // Two-stage synchroniser for the asynchronous switch pins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            switchMeta <= '0;
            switchSync <= '0;
        end else begin
            switchMeta <= iSwitch;
            switchSync <= switchMeta;
        end
    end

    // Free-running tick; any store to its address restarts it from zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sysTick <= '0;
        end else if (wrSysTick) begin
            sysTick <= '0;
        end else begin
            sysTick <= sysTick + 32'd1;
        end
    end

    always_comb begin
        oReadData = '0;
        if (oHit) begin
            case (regSel)
                REG_TH:      oReadData = th;
                REG_TL:      oReadData = tl;
                REG_TCON:    oReadData = {29'd0, tcon};
                REG_LED:     oReadData = {24'd0, led};
                REG_SWITCH:  oReadData = {24'd0, switchSync};
                REG_SYSTICK: oReadData = sysTick;
                default:     oReadData = '0;
            endcase
        end
    end

    assign oInterrupt = tcon[1] & tcon[2];
    assign oLed       = led;

endmodule

// File: tb/tb_timer_peripheral.sv
module tb_timer_peripheral;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] O_TH = 32'h00, O_TL = 32'h04, O_TCON = 32'h08;
    localparam logic [31:0] O_LED = 32'h0C, O_SW = 32'h10, O_TICK = 32'h14, O_OUT = 32'h18;

    logic        clk;
    logic        reset;
    logic [31:0] iAddr;
    logic        iMemRead;
    logic        iMemWrite;
    logic [31:0] iWriteData;
    logic [31:0] oReadData;
    logic        oHit;
    logic        oInterrupt;
    logic [7:0]  oLed;
    logic [7:0]  iSwitch;

    timer_peripheral #(.BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .reset      (reset),
        .iAddr      (iAddr),
        .iMemRead   (iMemRead),
        .iMemWrite  (iMemWrite),
        .iWriteData (iWriteData),
        .oReadData  (oReadData),
        .oHit       (oHit),
        .oInterrupt (oInterrupt),
        .oLed       (oLed),
        .iSwitch    (iSwitch)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int errors = 0;

    // Reference model: the six architectural words indexed by offset/4
    // (index 4 is the synchronised switch value) plus the first sync stage.
    logic [31:0] mReg [6];
    logic [7:0]  mSync1;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] off;
        logic [31:0] wdata;
        bit          expHit;
        logic [31:0] expData;
        bit          expIrq;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input bit rd, input bit wr, input logic [31:0] off, input logic [31:0] wdata,
                          input bit expHit, input logic [31:0] expData, input bit expIrq);
        vec_t v;
        v.rd = rd; v.wr = wr; v.off = off; v.wdata = wdata;
        v.expHit = expHit; v.expData = expData; v.expIrq = expIrq;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 6; i++) mReg[i] = '0;
        mSync1 = '0;
    endtask

    function automatic logic [31:0] modelRead(input logic rd, input logic wr, input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        if (!(rd || wr) || off >= 32'd24) return '0;
        return mReg[int'(off >> 2)];
    endfunction

    function automatic bit modelHit(input logic rd, input logic wr, input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return (rd || wr) && (off < 32'd24);
    endfunction

    task automatic drive(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] data);
        iMemRead = rd;
        iMemWrite = wr;
        iAddr = addr;
        iWriteData = data;
    endtask

    // Advance one rising edge, applying the register-map rules to the model
    // with the inputs currently on the bus. Returns at the following falling edge.
    task automatic tick();
        logic [31:0] nxt [6];
        logic [31:0] off;
        bit          store;
        int          idx;
        bit          wrap;
        off   = iAddr - BASE;
        store = iMemWrite && (off < 32'd24);
        idx   = int'(off >> 2);
        wrap  = mReg[2][0] && (mReg[1] == 32'hFFFF_FFFF);
        nxt   = mReg;
        if (mReg[2][0]) nxt[1] = wrap ? mReg[0] : mReg[1] + 32'd1;
        nxt[5] = mReg[5] + 32'd1;
        if (store) begin
            case (idx)
                0: nxt[0] = iWriteData;
                1: nxt[1] = iWriteData;
                2: nxt[2] = {29'd0, iWriteData[2:0]};
                3: nxt[3] = {24'd0, iWriteData[7:0]};
                5: nxt[5] = '0;
                default: ;
            endcase
        end
        if (wrap && mReg[2][1] && !(store && idx == 1)) nxt[2][2] = 1'b1;
        nxt[4] = {24'd0, mSync1};
        @(posedge clk);
        mReg = nxt;
        mSync1 = iSwitch;
        @(negedge clk);
    endtask

    task automatic op(input bit rd, input bit wr, input logic [31:0] off, input logic [31:0] data);
        drive(rd, wr, BASE + off, data);
        tick();
    endtask

    task automatic rdCheck(input string name, input logic [31:0] off, input logic [31:0] exp);
        drive(1'b1, 1'b0, BASE + off, '0);
        #1;
        check(name, oReadData, exp);
    endtask

    task automatic compareModel(input string tag);
        #1;
        check({tag, " hit"}, {31'd0, oHit}, {31'd0, modelHit(iMemRead, iMemWrite, iAddr)});
        check({tag, " rdata"}, oReadData, modelRead(iMemRead, iMemWrite, iAddr));
        check({tag, " irq"}, {31'd0, oInterrupt}, {31'd0, mReg[2][1] & mReg[2][2]});
        check({tag, " led"}, {24'd0, oLed}, mReg[3]);
    endtask

    initial begin
        reset = 1'b0;
        iSwitch = 8'h00;
        drive(1'b0, 1'b0, '0, '0);
        modelReset();

        // Reset held for three cycles.
        repeat (3) @(negedge clk);
        check("reset irq", {31'd0, oInterrupt}, 32'd0);
        check("reset led", {24'd0, oLed}, 32'd0);
        reset = 1'b1;

        // Directed table: each row is checked before its own edge, then ticked.
        addVec(1, 0, O_TICK, 0, 1, 32'h0, 0);
        addVec(1, 0, O_TH,   0, 1, 32'h0, 0);
        addVec(1, 0, O_TL,   0, 1, 32'h0, 0);
        addVec(1, 0, O_TCON, 0, 1, 32'h0, 0);
        addVec(1, 0, O_LED,  0, 1, 32'h0, 0);
        addVec(1, 0, O_SW,   0, 1, 32'h0, 0);
        addVec(0, 1, O_TH,   32'hFFFF_FFFC, 1, 32'h0, 0);
        addVec(0, 1, O_TL,   32'hFFFF_FFFE, 1, 32'h0, 0);
        addVec(0, 1, O_TCON, 32'h3, 1, 32'h0, 0);
        addVec(1, 0, O_TL,   0, 1, 32'hFFFF_FFFE, 0);
        addVec(1, 0, O_TL,   0, 1, 32'hFFFF_FFFF, 0);
        addVec(1, 0, O_TL,   0, 1, 32'hFFFF_FFFC, 1);
        addVec(1, 0, O_TCON, 0, 1, 32'h7, 1);
        addVec(0, 1, O_TCON, 32'h3, 1, 32'h7, 1);
        addVec(0, 1, O_TL,   32'h5, 1, 32'hFFFF_FFFF, 0);
        addVec(1, 0, O_TCON, 0, 1, 32'h3, 0);
        addVec(1, 0, O_TL,   0, 1, 32'h6, 0);
        addVec(1, 0, O_OUT,  0, 0, 32'h0, 0);
        addVec(0, 1, O_OUT,  32'h1234_5678, 0, 32'h0, 0);
        addVec(0, 1, O_LED,  32'h1A5, 1, 32'h0, 0);
        addVec(1, 0, O_LED,  0, 1, 32'hA5, 0);
        addVec(1, 0, O_TH,   0, 1, 32'hFFFF_FFFC, 0);
        addVec(1, 1, O_LED,  32'h5A, 1, 32'hA5, 0);
        addVec(1, 0, O_LED,  0, 1, 32'h5A, 0);
        addVec(0, 0, O_TH,   0, 0, 32'h0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rd, vecs[i].wr, BASE + vecs[i].off, vecs[i].wdata);
            #1;
            check($sformatf("row%0d hit", i), {31'd0, oHit}, {31'd0, vecs[i].expHit});
            check($sformatf("row%0d rdata", i), oReadData, vecs[i].expData);
            check($sformatf("row%0d irq", i), {31'd0, oInterrupt}, {31'd0, vecs[i].expIrq});
            check($sformatf("row%0d led", i), {24'd0, oLed}, mReg[3]);
            tick();
        end
        rdCheck("led after row sweep", O_LED, 32'h5A);
        check("oLed A5->5A", {24'd0, oLed}, 32'h5A);

        // Software clear racing the hardware status set.
        op(0, 1, O_TH, 32'h0);
        op(0, 1, O_TL, 32'hFFFF_FFFE);
        op(0, 0, O_TH, 0);
        op(0, 1, O_TCON, 32'h3);
        rdCheck("race same-edge tcon", O_TCON, 32'h7);
        check("race same-edge irq", {31'd0, oInterrupt}, 32'd1);
        op(0, 1, O_TCON, 32'h3);
        rdCheck("race next-cycle tcon", O_TCON, 32'h3);
        check("race next-cycle irq", {31'd0, oInterrupt}, 32'd0);

        // Asynchronous reset between edges while counting.
        op(0, 0, O_TH, 0);
        op(0, 0, O_TH, 0);
        drive(1'b1, 1'b0, BASE + O_TL, '0);
        compareModel("pre-reset");
        #1 reset = 1'b0;
        #1;
        check("async reset tl", oReadData, 32'h0);
        drive(1'b1, 1'b0, BASE + O_TCON, '0);
        #1;
        check("async reset tcon", oReadData, 32'h0);
        check("async reset irq", {31'd0, oInterrupt}, 32'd0);
        check("async reset led", {24'd0, oLed}, 32'd0);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        #2 reset = 1'b1;

        // Switch synchroniser: two edges to readback.
        iSwitch = 8'h3C;
        rdCheck("switch edge0", O_SW, 32'h0);
        tick();
        rdCheck("switch edge1", O_SW, 32'h0);
        tick();
        rdCheck("switch edge2", O_SW, 32'h3C);

        // SYSTICK restart and count.
        op(0, 1, O_TICK, 32'hDEAD_BEEF);
        repeat (10) op(0, 0, O_TH, 0);
        rdCheck("systick after 10", O_TICK, 32'd10);

        // Randomised traffic against the model.
        for (int n = 0; n < 400; n++) begin
            bit          rd;
            bit          wr;
            logic [31:0] addr;
            logic [31:0] data;
            logic [31:0] off;
            rd = ($urandom_range(0, 1) == 1);
            wr = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) < 8) addr = BASE + 32'($urandom_range(0, 31));
            else addr = $urandom;
            off = addr - BASE;
            data = $urandom;
            if (off[31:2] == 30'd1 && $urandom_range(0, 1) == 1) data = 32'hFFFF_FFFF - 32'($urandom_range(0, 4));
            if (off[31:2] == 30'd2 && $urandom_range(0, 3) != 0) data = {29'd0, 1'($urandom_range(0, 1)), 2'b11};
            if ($urandom_range(0, 15) == 0) iSwitch = 8'($urandom);
            drive(rd, wr, addr, data);
            compareModel($sformatf("rand%0d", n));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/timer_peripheral.md
# timer_peripheral

Memory-mapped peripheral block on the data-memory side of the pipelined CPU core. It decodes the core's MEM-stage bus (address, read, write, write data) and returns read data combinationally in the same cycle, so the core can capture load results at the MEM/WB boundary. It holds a reloadable 32-bit interval timer that raises the core's interrupt request, plus an LED output register, a synchronised switch input and a free-running system tick counter. An outer bus mux selects between this block and data RAM using `oHit`.

## Interface
- `BASE_ADDR`, default 32'h4000_0000: word-aligned base of the 0x18-byte register window.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low; clears all state.
- `iAddr` input 32: byte address from the core's MEM stage.
- `iMemRead` input 1: load strobe, qualifies `oHit`.
- `iMemWrite` input 1: store strobe; the write commits at the next rising edge.
- `iWriteData` input 32: store data.
- `oReadData` output 32: combinational read data; 0 when there is no hit.
- `oHit` output 1: combinational; `(iMemRead|iMemWrite)` and `iAddr` lies in [BASE_ADDR, BASE_ADDR+0x18).
- `oInterrupt` output 1: registered-state IRQ to the core, equal to TCON[1] & TCON[2].
- `oLed` output 8: LED register.
- `iSwitch` input 8: asynchronous switch pins.

## Operation
Register map, offsets from BASE_ADDR. `iAddr[1:0]` is ignored, and only word accesses are supported.
- 0x00 TH: reload value, RW.
- 0x04 TL: counter, RW.
- 0x08 TCON: RW in bits [2:0]; bits [31:3] read 0.
  - [0] is the enable bit.
  - [1] is the IRQ enable bit.
  - [2] is the IRQ status bit.
- 0x0C LED: RW in bits [7:0]; upper bits read 0.
- 0x10 SWITCH: read-only, zero-extended synchronised switches; writes are ignored.
- 0x14 SYSTICK: read-only; counts +1 every cycle and wraps at 2^32. Any write clears it to 0 on that edge.

Timer rules, evaluated every rising edge:
- When TCON[0]=1 and TL≠32'hFFFF_FFFF, TL ← TL+1.
- When TCON[0]=1 and TL=32'hFFFF_FFFF (overflow):
  - TL ← TH.
  - If TCON[1]=1, TCON[2] ← 1.
- When TCON[0]=0, TL holds its value.

Simultaneous events:
- A store to TL in the same cycle as an increment or overflow: the stored value wins, and an overflow in that cycle does not set TCON[2].
- A store to TCON writes [2:0] directly, with one exception. If an overflow sets status in the same cycle and TCON[1] (old value) = 1, TCON[2] ends at 1: the hardware set beats the software clear, so no interrupt is lost.
- A store to TH while TL is overflowing: the reload uses the old TH.

Other rules:
- Reads have no side effects.
- A store with `iMemRead` also high behaves as a store.
- Addresses outside the window: `oHit`=0, `oReadData`=0, no state change.

Switch synchroniser: two flops in series; SWITCH reads the second flop.

## Timing
- Read latency is 0 cycles: `oReadData` is purely combinational from `iAddr` and current register state.
- Store latency is 1 edge: the new value is visible to a read in the following cycle.
- `oInterrupt` rises in the cycle after the overflow edge, i.e. combinationally from TCON after that edge. It stays high until software clears TCON[2] or TCON[1].
- Switch change to SWITCH readback takes 2 rising edges.
- Reset values, also forced asynchronously when `reset` falls mid-count:
  - TH, TL, TCON, LED, SYSTICK and both synchroniser stages = 0.
  - `oInterrupt`=0, `oLed`=0.
- First count happens on the first rising edge after `reset` rises with TCON[0]=1.

## Test plan
- Reset then readback: hold `reset`=0 for 3 cycles, then read all six offsets. All return 0, and `oInterrupt`=0, `oLed`=0.
- Overflow and reload:
  - Write TH=32'hFFFF_FFFC, TL=32'hFFFF_FFFE, TCON=3.
  - TL reads FFFF_FFFF after edge 1 and FFFF_FFFC after edge 2, and TCON reads 7.
  - `oInterrupt`=1 from the cycle after edge 2.
- Clear vs set race: arrange a store of TCON=3 on the same edge that TL overflows. TCON reads 7 afterwards and `oInterrupt` stays 1. Repeating with the store one cycle after the overflow edge yields TCON=3 and `oInterrupt`=0.
- TL store beats overflow: with TL=FFFF_FFFF and TCON=3, store TL=5 on that edge. TL reads 5 next cycle and TCON[2]=0.
- LED, switch and SYSTICK:
  - Store LED=32'h1A5 and read back 32'hA5; `oLed`=8'hA5.
  - Drive `iSwitch`=8'h3C; SWITCH reads 0x3C from 2 edges later.
  - Store to SYSTICK, then read it 10 cycles later: the value is 10 (±1 per bench sampling point, fixed in the bench).
- Out-of-window and async reset:
  - Access BASE_ADDR+0x18: `oHit`=0, `oReadData`=0, no register changes.
  - Assert `reset` between edges while counting: TL and TCON read 0 immediately, without waiting for a clock edge.
